// File: rtl/mult_arbiter_pkg.sv
// Shared co-processor definitions: default arbiter sizing and FSM state encodings.
package mult_arbiter_pkg;

  localparam int DEF_N_REQ = 4;
  localparam int DEF_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ISSUE    = 2'd1,
    WAIT_RES = 2'd2,
    DELIVER  = 2'd3
  } arb_state_t;

endpackage

// File: rtl/mult_arbiter_rr_pick.sv
// Round-robin winner search: first requester strictly after ptr, wrapping to 0.
module rr_pick
  import mult_arbiter_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ,
  parameter int IDX_W = $clog2(DEF_N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic             valid,
  output logic [IDX_W-1:0] idx
);

  // Scan from the farthest candidate back toward ptr+1 so the nearest requester overwrites the rest.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      if (req[IDX_W'((int'(ptr) + k) % N_REQ)]) begin
        valid = 1'b1;
        idx   = IDX_W'((int'(ptr) + k) % N_REQ);
      end
    end
  end

endmodule

// File: rtl/mult_arbiter.sv
// Shares one external multiplier between N_REQ requesters, one operation in flight,
// with round-robin granting among simultaneous requests.
module mult_arbiter
  import mult_arbiter_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ,
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ*WIDTH-1:0]   req_a,
  input  logic [N_REQ*WIDTH-1:0]   req_b,
  input  logic [N_REQ-1:0]         req_stb,
  output logic [N_REQ-1:0]         req_busy,
  output logic [WIDTH-1:0]         rsp_result,
  output logic [N_REQ-1:0]         rsp_stb,
  input  logic [N_REQ-1:0]         rsp_busy,
  output logic [WIDTH-1:0]         m_a,
  output logic [WIDTH-1:0]         m_b,
  output logic                     m_in_stb,
  input  logic                     m_busy,
  input  logic [WIDTH-1:0]         m_result,
  input  logic                     m_out_stb,
  output logic                     m_out_busy,
  output logic [$clog2(N_REQ)-1:0] grant_id
);

  localparam int ID_W = $clog2(N_REQ);

  arb_state_t      state;
  arb_state_t      next_state;
  logic [ID_W-1:0] ptr;
  logic            pick_valid;
  logic [ID_W-1:0] pick_idx;
  logic            accept;
  logic            issue_done;
  logic            result_take;
  logic            deliver_done;

  rr_pick #(
    .N_REQ (N_REQ),
    .IDX_W (ID_W)
  ) u_rr_pick (
    .req   (req_stb),
    .ptr   (ptr),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  // Only the current winner sees a ready request side, and only while idle and out of reset.
  always_comb begin
    req_busy = '1;
    if (state == IDLE && rst && pick_valid) begin
      req_busy[pick_idx] = 1'b0;
    end
  end

  // Next-state logic plus one-cycle event flags for each completed handshake.
  always_comb begin
    next_state   = state;
    accept       = 1'b0;
    issue_done   = 1'b0;
    result_take  = 1'b0;
    deliver_done = 1'b0;
    unique case (state)
      IDLE: begin
        if (pick_valid) begin
          accept     = 1'b1;
          next_state = ISSUE;
        end
      end
      ISSUE: begin
        if (m_in_stb && !m_busy) begin
          issue_done = 1'b1;
          next_state = WAIT_RES;
        end
      end
      WAIT_RES: begin
        if (m_out_stb && !m_out_busy) begin
          result_take = 1'b1;
          next_state  = DELIVER;
        end
      end
      DELIVER: begin
        if (!rsp_busy[grant_id]) begin
          deliver_done = 1'b1;
          next_state   = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // State register; reset abandons any operation in flight.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Datapath and handshake registers, updated on the flags from the FSM.
  always_ff @(posedge clk) begin
    if (!rst) begin
      ptr        <= ID_W'(N_REQ - 1);
      m_a        <= '0;
      m_b        <= '0;
      grant_id   <= '0;
      m_in_stb   <= 1'b0;
      m_out_busy <= 1'b1;
      rsp_stb    <= '0;
      rsp_result <= '0;
    end else begin
      if (accept) begin
        m_a      <= req_a[int'(pick_idx)*WIDTH +: WIDTH];
        m_b      <= req_b[int'(pick_idx)*WIDTH +: WIDTH];
        grant_id <= pick_idx;
        m_in_stb <= 1'b1;
      end
      if (issue_done) begin
        m_in_stb   <= 1'b0;
        m_out_busy <= 1'b0;
      end
      if (result_take) begin
        rsp_result        <= m_result;
        m_out_busy        <= 1'b1;
        rsp_stb           <= '0;
        rsp_stb[grant_id] <= 1'b1;
      end
      if (deliver_done) begin
        rsp_stb <= '0;
        ptr     <= grant_id;
      end
    end
  end

endmodule

// File: doc/mult_arbiter.md
MULT_ARBITER -- requirements
Module: mult_arbiter

Interface
REQ-001 Parameter N_REQ, default 4, number of requester ports (2..8).
REQ-002 Parameter WIDTH, default 16, operand and result width.
REQ-003 clk  input  1  clock; every register updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-low.
REQ-005 req_a  input  N_REQ*WIDTH  operand A per port; port i occupies bits [i*WIDTH +: WIDTH].
REQ-006 req_b  input  N_REQ*WIDTH  operand B per port, same packing as req_a.
REQ-007 req_stb  input  N_REQ  request strobe per port.
REQ-008 req_busy  output  N_REQ  request-side busy per port.
REQ-009 rsp_result  output  WIDTH  result returned to the granted port.
REQ-010 rsp_stb  output  N_REQ  result strobe per port.
REQ-011 rsp_busy  input  N_REQ  requester not ready for a result.
REQ-012 m_a, m_b  output  WIDTH  operands to the shared multiplier.
REQ-013 m_in_stb  output  1  multiplier input strobe.
REQ-014 m_busy  input  1  multiplier input busy.
REQ-015 m_result  input  WIDTH  multiplier product.
REQ-016 m_out_stb  input  1  multiplier output strobe.
REQ-017 m_out_busy  output  1  arbiter not ready for a product.
REQ-018 grant_id  output  clog2(N_REQ)  index of the current or last granted port.

Function
REQ-019 Every handshake shall transfer on a rising edge where stb=1 and busy=0; a strobe shall hold until it transfers.
REQ-020 The FSM shall have states IDLE, ISSUE, WAIT_RES and DELIVER.
REQ-021 In IDLE, the winner shall be the first port with req_stb=1, searched from ptr+1 upward and wrapping from N_REQ-1 to 0.
REQ-022 req_busy[i] shall be combinational: 0 only when state=IDLE, rst=1 and i is the winner; 1 otherwise.
REQ-023 On IDLE acceptance: latch the winner's operands into m_a/m_b, set grant_id to the winner, set m_in_stb=1, and go to ISSUE.
REQ-024 ISSUE: when m_in_stb=1 and m_busy=0, set m_in_stb=0 and m_out_busy=0, and go to WAIT_RES.
REQ-025 WAIT_RES: when m_out_stb=1 and m_out_busy=0, capture m_result into rsp_result, set m_out_busy=1, set rsp_stb[grant_id]=1, and go to DELIVER.
REQ-026 DELIVER: when rsp_busy[grant_id]=0, clear rsp_stb, set ptr to grant_id, and go to IDLE.
REQ-027 At most one rsp_stb bit shall be high at any time; no new grant shall occur outside IDLE (one operation in flight).
REQ-028 Minimum latency from request acceptance to rsp_stb shall be 3 cycles plus the multiplier latency.
REQ-029 Simultaneous requests shall be served round-robin; a port requesting continuously shall wait at most N_REQ-1 other grants.
REQ-030 A requester raising req_stb in the same cycle its previous response completes shall be eligible in the next IDLE cycle, at lowest priority.
REQ-031 Operands and results shall pass through unmodified at WIDTH bits; the arbiter shall not perform any arithmetic.

Reset
REQ-032 While rst=0: state=IDLE, ptr=N_REQ-1 (port 0 has first priority), m_in_stb=0, m_out_busy=1, rsp_stb=0, rsp_result=0, m_a=0, m_b=0, grant_id=0, req_busy=all 1s.
REQ-033 Reset asserted mid-operation shall abandon the operation; the product arriving after reset is not consumed, because m_out_busy=1.

Structure
REQ-034 The state encodings (2-bit) and the default N_REQ/WIDTH shall live in the shared co-processor package.
REQ-035 The round-robin winner search shall be one combinational sub-module, rr_pick, with inputs req and ptr and outputs valid and idx.
REQ-036 The multiplier shall remain external; mult_arbiter connects to it only through its m_* ports.

Verification
REQ-037 Single request: port 2 sends a=7, b=6 with a 1-cycle multiplier model -> rsp_stb[2]=1 with rsp_result=42; all other rsp_stb bits stay 0; grant_id=2.
REQ-038 All four ports request together after reset -> grant order 0,1,2,3; operands (1,2), (3,4), (5,6), (7,8) return 2, 12, 30, 56.
REQ-039 Backpressure: m_busy held high for 5 cycles in ISSUE -> m_in_stb stays 1 with stable operands, then drops 1 cycle after m_busy falls; rsp_busy[1] held high for 4 cycles -> rsp_stb[1] and rsp_result stay stable.
REQ-040 Fairness: port 0 requests continuously while port 3 requests once -> port 3 is granted immediately after the current port-0 operation.
REQ-041 Reset in WAIT_RES: rst=0 for 1 cycle -> next cycle state=IDLE, m_out_busy=1, rsp_stb=0, req_busy all 1s during reset; a late m_out_stb is ignored.
REQ-042 Overflow pass-through: a=16'hFFFF, b=16'h0002 with a model product of 16'hFFFE -> rsp_result=16'hFFFE exactly.
